cacheline_arbiter: RTL and testbench

Parametrised, multi-channel successor to the single-port cache-line adaptor. It sits between `NUM_CH` cache memory ports (for example, split I-cache and D-cache) and the single burst memory bus. It arbitrates round-robin among the pending line requests. Each granted request is converted into a sequence of `LINE_W/BURST_W` bursts on the memory side, and read bursts are reassembled into a full line before they are returned to the requester.

---
 rtl/cacheline_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cacheline_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter + line/burst adaptor: NUM_CH cache line ports onto one burst memory bus.
// Latency: grant 1 cycle after request, then BEATS accepted beats, then a 1-cycle resp pulse.
// Backpressure: memory paces beats with resp_i (gaps allowed); clients hold requests until resp.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   ch_address_i/read_i/write_i/line_i per-channel line requests (slice c = channel c)
//   line_o, ch_resp_o                 returned line and one-hot completion pulse
//   address_o, read_o, write_o        memory request (held for the whole transaction)
//   burst_o, burst_i, resp_i          write beat, read beat, beat strobe
module cacheline_arbiter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address_i,
  input  logic [NUM_CH-1:0]          ch_read_i,
  input  logic [NUM_CH-1:0]          ch_write_i,
  input  logic [NUM_CH*LINE_W-1:0]   ch_line_i,
  output logic [LINE_W-1:0]          line_o,
  output logic [NUM_CH-1:0]          ch_resp_o,
  input  logic [BURST_W-1:0]         burst_i,
  output logic [BURST_W-1:0]         burst_o,
  output logic [ADDR_W-1:0]          address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic                       resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e             state_q, state_d;
  // last_grant doubles as the grant index of the transaction in flight.
  logic [GNT_W-1:0]   last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  line_buf_q, line_buf_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_CH-1:0]  pending;
  logic               found;
  logic [GNT_W-1:0]   pick;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LINE_W-1:0]  sel_line;
  logic               last_beat;

  assign pending   = ch_read_i | ch_write_i;
  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  // Round-robin search: first pass covers channels above last_grant, second pass
  // wraps around to channels at or below it, so the search starts at last_grant+1.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_line = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && pending[j] &&
            ((pass == 0) ? (GNT_W'(j) > last_grant_q) : (GNT_W'(j) <= last_grant_q))) begin
          found    = 1'b1;
          pick     = GNT_W'(j);
          sel_wr   = ch_write_i[j];  // write wins when both are raised
          sel_addr = ch_address_i[j*ADDR_W +: ADDR_W];
          sel_line = ch_line_i[j*LINE_W +: LINE_W];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    line_buf_d   = line_buf_q;
    beat_cnt_d   = beat_cnt_q;
    read_o       = 1'b0;
    write_o      = 1'b0;
    address_o    = '0;
    burst_o      = '0;
    line_o       = '0;
    ch_resp_o    = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          last_grant_d     = pick;
          addr_d           = sel_addr;
          addr_d[OFF-1:0]  = '0;
          beat_cnt_d       = '0;
          if (sel_wr) begin
            line_buf_d = sel_line;
            state_d    = WRITE;
          end else begin
            state_d    = READ;
          end
        end
      end

      READ: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (resp_i) begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) line_buf_d[b*BURST_W +: BURST_W] = burst_i;
          end
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      WRITE: begin
        write_o   = 1'b1;
        address_o = addr_q;
        for (int b = 0; b < BEATS; b++) begin
          if (beat_cnt_q == CNT_W'(b)) burst_o = line_buf_q[b*BURST_W +: BURST_W];
        end
        if (resp_i) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      RESP: begin
        line_o = line_buf_q;
        for (int j = 0; j < NUM_CH; j++) begin
          if (GNT_W'(j) == last_grant_q) ch_resp_o[j] = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_W'(NUM_CH - 1);  // channel 0 has first priority
      addr_q       <= '0;
      line_buf_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      line_buf_q   <= line_buf_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: default 2-channel instance plus a 3-channel
// 128/32 instance. Inputs change on the falling edge, outputs are sampled there too.
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;

  // default instance
  logic [63:0]  ch_address_i = '0;
  logic [1:0]   ch_read_i = '0;
  logic [1:0]   ch_write_i = '0;
  logic [511:0] ch_line_i = '0;
  logic [255:0] line_o;
  logic [1:0]   ch_resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic         resp_i = 1'b0;

  // three-channel instance
  logic [95:0]  c3_addr = '0;
  logic [2:0]   c3_rd = '0;
  logic [2:0]   c3_wr = '0;
  logic [383:0] c3_line = '0;
  logic [127:0] c3_line_o;
  logic [2:0]   c3_resp;
  logic [31:0]  c3_burst_i = '0;
  logic [31:0]  c3_burst_o;
  logic [31:0]  c3_address_o;
  logic         c3_read_o, c3_write_o;
  logic         c3_resp_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cacheline_arbiter u_dut (
    .clk(clk), .reset_n(reset_n),
    .ch_address_i(ch_address_i), .ch_read_i(ch_read_i), .ch_write_i(ch_write_i),
    .ch_line_i(ch_line_i), .line_o(line_o), .ch_resp_o(ch_resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  cacheline_arbiter #(.LINE_W(128), .BURST_W(32), .NUM_CH(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .ch_address_i(c3_addr), .ch_read_i(c3_rd), .ch_write_i(c3_wr),
    .ch_line_i(c3_line), .line_o(c3_line_o), .ch_resp_o(c3_resp),
    .burst_i(c3_burst_i), .burst_o(c3_burst_o), .address_o(c3_address_o),
    .read_o(c3_read_o), .write_o(c3_write_o), .resp_i(c3_resp_i)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one transaction on the default instance. Call in the negedge of an IDLE
  // cycle whose following edge grants. pat bit i = resp_i in the i-th bus cycle.
  // line = data returned by memory (read) or expected on burst_o (write).
  task automatic serve(input string tag, input bit is_wr, input logic [31:0] exp_addr,
                       input logic [255:0] line, input logic [15:0] pat,
                       input logic [1:0] exp_resp, input bit drop);
    int w = 0;
    int beats = 0;
    int cyc = 0;
    logic [1:0] exp_op;
    exp_op = is_wr ? 2'b01 : 2'b10;
    do begin
      @(negedge clk);
      w++;
    end while (!(read_o || write_o) && w < 8);
    check({tag, ".latency"}, w, 1);
    check({tag, ".op"}, {read_o, write_o}, exp_op);
    check({tag, ".addr"}, address_o, exp_addr);
    while (beats < 4 && cyc < 16) begin
      check({tag, ".held"}, {read_o, write_o}, exp_op);
      check({tag, ".noresp"}, ch_resp_o, 2'b00);
      resp_i  = pat[cyc];
      burst_i = (!is_wr && pat[cyc]) ? line[beats*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (is_wr && pat[cyc]) check({tag, ".burst"}, burst_o, line[beats*64 +: 64]);
      if (pat[cyc]) beats++;
      @(negedge clk);
      cyc++;
    end
    resp_i = 1'b0;
    check({tag, ".beats"}, beats, 4);
    check({tag, ".resp"}, ch_resp_o, exp_resp);
    check({tag, ".line"}, line_o, line);
    check({tag, ".busidle"}, {read_o, write_o}, 2'b00);
    if (drop) begin
      ch_read_i  = '0;
      ch_write_i = '0;
    end
    @(negedge clk);
    check({tag, ".pulse"}, ch_resp_o, 2'b00);
  endtask

  function automatic logic [31:0] beat3(input int k, input int b);
    return 32'hA000_0000 + 32'(k * 256 + b);
  endfunction

  initial begin
    logic [255:0] lr, lw;
    logic [31:0]  a3_exp [3];
    int k, b;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.read", read_o, 1'b0);
    check("rst.write", write_o, 1'b0);
    check("rst.resp", ch_resp_o, 2'b00);
    check("rst.addr", address_o, 32'h0);
    check("rst.burst", burst_o, 64'h0);
    check("rst.line", line_o, 256'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // single read, back-to-back beats
    lr = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    ch_address_i[31:0] = 32'h0000_1234;
    ch_read_i = 2'b01;
    serve("rd", 1'b0, 32'h0000_1220, lr, 16'hFFFF, 2'b01, 1'b1);

    // single write on ch1; request data changes after grant must be ignored
    lw = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
          64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    ch_address_i[63:32] = 32'h8000_0040;
    ch_line_i[511:256]  = lw;
    ch_write_i = 2'b10;
    @(posedge clk);
    #1;
    ch_line_i[511:256]  = '1;
    ch_address_i[63:32] = 32'hFFFF_FFFF;
    serve("wr", 1'b1, 32'h8000_0040, lw, 16'hFFFF, 2'b10, 1'b1);

    // stalls: resp_i 1,0,0,1,1,0,1
    lr = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
          64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
    ch_address_i[31:0] = 32'h2000_0000;
    ch_read_i = 2'b01;
    serve("stall", 1'b0, 32'h2000_0000, lr, 16'h0059, 2'b01, 1'b1);

    // read+write on the same channel: write wins
    lw = {64'h0C0C_0000_0000_0003, 64'h0C0C_0000_0000_0002,
          64'h0C0C_0000_0000_0001, 64'h0C0C_0000_0000_0000};
    ch_address_i[31:0] = 32'h3000_003F;
    ch_line_i[255:0]   = lw;
    ch_read_i  = 2'b01;
    ch_write_i = 2'b01;
    serve("conflict", 1'b1, 32'h3000_0020, lw, 16'hFFFF, 2'b01, 1'b1);

    // reset in the middle of a read, after two beats
    ch_address_i[31:0] = 32'h0000_5000;
    ch_read_i = 2'b01;
    @(negedge clk);
    check("mid.read", read_o, 1'b1);
    resp_i  = 1'b1;
    burst_i = 64'h1;
    @(negedge clk);
    burst_i = 64'h2;
    @(negedge clk);
    resp_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid.read_low", read_o, 1'b0);
    check("mid.addr_low", address_o, 32'h0);
    ch_read_i = 2'b10;
    ch_address_i[63:32] = 32'h0000_6010;
    @(negedge clk);
    check("mid.noresp", ch_resp_o, 2'b00);
    reset_n = 1'b1;
    lr = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
          64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
    serve("after_rst", 1'b0, 32'h0000_6000, lr, 16'hFFFF, 2'b10, 1'b1);

    // round robin with both channels requesting continuously
    ch_address_i = {32'h0000_B0A0, 32'h0000_A0C0};
    ch_read_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      lr = {4{64'h5200_0000_0000_0000 | 64'(t)}};
      lr[63:56] = 8'(t + 8'h10);
      serve($sformatf("rr%0d", t), 1'b0, (t % 2 == 0) ? 32'h0000_A0C0 : 32'h0000_B0A0,
            lr, 16'hFFFF, (t % 2 == 0) ? 2'b01 : 2'b10, t == 3);
    end

    // three-channel instance, 128-bit lines of 32-bit beats
    a3_exp[0] = 32'h0000_1000;
    a3_exp[1] = 32'h0000_2020;
    a3_exp[2] = 32'h0000_3030;
    c3_addr   = {32'h0000_3035, 32'h0000_2027, 32'h0000_100F};
    c3_rd     = 3'b111;
    c3_resp_i = 1'b1;
    k = 0;
    b = 0;
    for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
      @(negedge clk);
      if (c3_read_o) begin
        if (b == 0) check($sformatf("p3.addr%0d", k), c3_address_o, a3_exp[k % 3]);
        c3_burst_i = beat3(k, b);
        b++;
      end
      if (c3_resp != 3'b000) begin
        check($sformatf("p3.resp%0d", k), c3_resp, 3'b001 << (k % 3));
        check($sformatf("p3.beats%0d", k), b, 4);
        check($sformatf("p3.line%0d", k), c3_line_o,
              {beat3(k, 3), beat3(k, 2), beat3(k, 1), beat3(k, 0)});
        k++;
        b = 0;
      end
    end
    c3_rd = '0;
    c3_resp_i = 1'b0;
    check("p3.count", k, 4);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
